mmio_store_capture: RTL and testbench
=====================================

// Module: mmio_store_capture
// PURPOSE
//  Sits on the core's data-memory write port beside dmem. Captures every store to the debug window
//  (word address MADDR[31:20] == MATCH_HI) into a FIFO, drained over a valid/ready stream.
//  The stream feeds the bench console/UART model.
//  A store to HALT_WADDR is not queued. It latches a sticky HALT flag and an exit code; the bench
//  uses this to end simulation instead of polling PC.
// PARAMETERS
//  DEPTH      16             FIFO entries, power of two, >= 2
//  AW         4              log2(DEPTH)
//  MATCH_HI   12'h001        MADDR[31:20] value selecting the debug window
//  HALT_WADDR 32'h001FFFFF   word address of the halt/exit-code register (inside window)
// PORTS
//  CLK        in   1      clock, all state on posedge
//  RST        in   1      reset, asynchronous, active-high
//  DMWE       in   1      data-memory write enable from core (one store per cycle max)
//  DMBE       in   4      byte enables of the store
//  MADDR      in   32     word address of the store
//  WDATA      in   32     store data (RF_DATA2 after byte alignment)
//  OUT_VALID  out  1      FIFO head valid
//  OUT_READY  in   1      consumer accepts head this cycle
//  OUT_ADDR   out  32     head entry word address
//  OUT_DATA   out  32     head entry data
//  OUT_BE     out  4      head entry byte enables
//  LEVEL      out  AW+1   number of queued entries, 0..DEPTH
//  DROP_CNT   out  16     stores lost to overflow, saturating
//  CLR_DROP   in   1      synchronous clear of DROP_CNT
//  HALT       out  1      sticky: halt register written
//  HALT_CODE  out  32     data of the first halt store
// BEHAVIOUR
//  Reset (async, immediate): pointers=0, LEVEL=0, OUT_VALID=0, DROP_CNT=0, HALT=0, HALT_CODE=0.
//   OUT_ADDR/DATA/BE=0 (entry storage need not clear; outputs are masked to 0 while empty).
//  hit  = DMWE & (MADDR[31:20]==MATCH_HI)
//  push = hit & (MADDR!=HALT_WADDR)
//  hstb = hit & (MADDR==HALT_WADDR)
//  FIFO: first-word-fall-through.
//   - OUT_VALID = (LEVEL!=0); OUT_* reflect the head combinationally from registered storage.
//   - A push at edge N makes the entry visible at OUT_* after edge N (latency 1 cycle), if the FIFO
//     was empty.
//  pop = OUT_VALID & OUT_READY; head advances at that edge.
//   - OUT_* must stay stable while OUT_VALID & ~OUT_READY.
//  Pointers: AW+1 bits with wrap bit.
//   - empty = (wp==rp); full = (wp[AW]!=rp[AW]) & (wp[AW-1:0]==rp[AW-1:0]).
//   - Wrap from DEPTH-1 to 0 is seamless.
//  Simultaneous push & pop:
//   - Both occur; LEVEL unchanged.
//   - Allowed when full (the pop frees the slot; the push is accepted, not dropped).
//   - When empty, pop cannot occur (OUT_VALID=0), so push alone occurs.
//  Overflow: push & full & ~pop -> entry discarded, FIFO unchanged, DROP_CNT+1.
//   - DROP_CNT saturates at 16'hFFFF.
//   - CLR_DROP has priority over increment in the same cycle (result 0).
//  Halt:
//   - First hstb sets HALT=1 and HALT_CODE=WDATA (full word; DMBE ignored).
//   - Later hstb ignored; only RST clears HALT.
//   - Captures and drains continue after HALT.
//  Stores with DMWE=0 or outside window: no effect. Loads are never observed.
//  LEVEL registered, updated at the same edge as pointers.
// TESTING
//  T1 reset: assert RST mid-burst with 5 queued -> OUT_VALID=0, LEVEL=0, DROP_CNT=0 immediately,
//     without waiting for CLK.
//  T2 latency/order: stores A=0x00100000,D=0x11, then 0x00100001,D=0x22, OUT_READY=0 -> LEVEL=2;
//     OUT_DATA=0x11 one cycle after the first store; raise OUT_READY -> 0x11 then 0x22, then
//     OUT_VALID=0.
//  T3 overflow: 18 stores, OUT_READY=0, DEPTH=16 -> LEVEL=16, DROP_CNT=2.
//     Drain -> data of stores 1..16 in order.
//  T4 full push+pop: fill 16, then store D=0xAB with OUT_READY=1 same cycle -> LEVEL stays 16,
//     DROP_CNT=0, 0xAB is last out.
//  T5 wrap: 40 push/pop pairs, random OUT_READY -> stream matches reference queue, no loss or dup.
//  T6 halt/filter: store to 0x00200000 -> ignored.
//     Store 0x001FFFFF,D=0x0 -> HALT=1, HALT_CODE=0, LEVEL unchanged.
//     Second halt store D=0x5 -> HALT_CODE stays 0.

Source files
------------

// File: rtl/mmio_store_capture_if.sv
// Store-snoop and capture-stream bundle for mmio_store_capture.
// slave: the capture block. master: the core/consumer side that drives stores and drains entries.
interface mmio_store_capture_if #(
    parameter int unsigned AW = 4
);
    logic          dmwe;
    logic [3:0]    dmbe;
    logic [31:0]   maddr;
    logic [31:0]   wdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_addr;
    logic [31:0]   out_data;
    logic [3:0]    out_be;
    logic [AW:0]   level;
    logic [15:0]   drop_cnt;
    logic          clr_drop;
    logic          halt;
    logic [31:0]   halt_code;

    modport slave (
        input  dmwe, dmbe, maddr, wdata, out_ready, clr_drop,
        output out_valid, out_addr, out_data, out_be, level, drop_cnt, halt, halt_code
    );

    modport master (
        output dmwe, dmbe, maddr, wdata, out_ready, clr_drop,
        input  out_valid, out_addr, out_data, out_be, level, drop_cnt, halt, halt_code
    );
endinterface

// File: rtl/mmio_store_capture.sv
// Snoops data-memory stores and queues those that land in the debug window into a
// first-word-fall-through FIFO. A store to the halt register latches a sticky halt
// flag and exit code instead of being queued.
module mmio_store_capture #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4,
    parameter logic [11:0] MATCH_HI   = 12'h001,
    parameter logic [31:0] HALT_WADDR = 32'h001FFFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mmio_store_capture_if.slave  bus
);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    entry_t      mem_q [DEPTH];
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] rp_q, rp_d;
    logic [AW:0] level_q, level_d;
    logic [15:0] drop_q, drop_d;
    logic        halt_q, halt_d;
    logic [31:0] code_q, code_d;

    logic   hit, push, hstb, empty, full, pop, accept;
    entry_t head;

    // Classify the store, derive FIFO flags and next-state for pointers, level, drop counter and halt.
    always_comb begin
        hit    = bus.dmwe & (bus.maddr[31:20] == MATCH_HI);
        push   = hit & (bus.maddr != HALT_WADDR);
        hstb   = hit & (bus.maddr == HALT_WADDR);
        empty  = (wp_q == rp_q);
        full   = (wp_q[AW] != rp_q[AW]) & (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop    = ~empty & bus.out_ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        accept = push & (~full | pop);

        wp_d    = accept ? wp_q + ONE : wp_q;
        rp_d    = pop ? rp_q + ONE : rp_q;
        level_d = level_q;
        unique case ({accept, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        drop_d = drop_q;
        if (bus.clr_drop) begin
            drop_d = '0;
        end else if (push & ~accept & (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end

        halt_d = halt_q;
        code_d = code_q;
        if (hstb & ~halt_q) begin
            halt_d = 1'b1;
            code_d = bus.wdata;
        end
    end

    // Control and status state; cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            drop_q  <= '0;
            halt_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            drop_q  <= drop_d;
            halt_q  <= halt_d;
            code_q  <= code_d;
        end
    end

    // Entry storage; contents are don't-care while empty because the outputs are masked.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wp_q[AW-1:0]] <= '{addr: bus.maddr, data: bus.wdata, be: bus.dmbe};
        end
    end

    assign head          = mem_q[rp_q[AW-1:0]];
    assign bus.out_valid = ~empty;
    assign bus.out_addr  = empty ? '0 : head.addr;
    assign bus.out_data  = empty ? '0 : head.data;
    assign bus.out_be    = empty ? '0 : head.be;
    assign bus.level     = level_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.halt      = halt_q;
    assign bus.halt_code = code_q;

endmodule

// File: tb/tb_mmio_store_capture.sv
// Self-checking bench for mmio_store_capture: directed scenarios with literal expectations
// plus a randomized phase, all tracked by a queue-based reference model.
module tb_mmio_store_capture;

    localparam logic [31:0] HALT_A = 32'h001FFFFF;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    mmio_store_capture_if #(.AW(4)) bus ();

    mmio_store_capture #(
        .DEPTH(16),
        .AW(4),
        .MATCH_HI(12'h001),
        .HALT_WADDR(32'h001FFFFF)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of {addr,data,be}, drop count, halt state.
    logic [67:0] mq[$];
    int unsigned m_drop;
    logic        m_halt;
    logic [31:0] m_code;

    // Compare the DUT against the model every cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic        hit, push, hstb, pop;
        logic [67:0] e;
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_halt = 1'b0;
            m_code = '0;
        end
        check("m_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("m_level", 32'(bus.level), 32'(mq.size()));
        check("m_drop", 32'(bus.drop_cnt), m_drop);
        check("m_halt", 32'(bus.halt), 32'(m_halt));
        check("m_code", bus.halt_code, m_code);
        if (mq.size() != 0) begin
            e = mq[0];
            check("m_addr", bus.out_addr, e[67:36]);
            check("m_data", bus.out_data, e[35:4]);
            check("m_be", 32'(bus.out_be), 32'(e[3:0]));
        end else begin
            check("m_addr0", bus.out_addr, 32'h0);
            check("m_data0", bus.out_data, 32'h0);
            check("m_be0", 32'(bus.out_be), 32'h0);
        end
        if (!rst) begin
            hit  = bus.dmwe && (bus.maddr[31:20] == 12'h001);
            push = hit && (bus.maddr != HALT_A);
            hstb = hit && (bus.maddr == HALT_A);
            pop  = (mq.size() != 0) && bus.out_ready;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < 16) mq.push_back({bus.maddr, bus.wdata, bus.dmbe});
                else if (!bus.clr_drop && m_drop < 32'hFFFF) m_drop++;
            end
            if (bus.clr_drop) m_drop = 0;
            if (hstb && !m_halt) begin
                m_halt = 1'b1;
                m_code = bus.wdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.dmwe  = 1'b1;
        bus.maddr = a;
        bus.wdata = d;
        bus.dmbe  = be;
        cyc();
        bus.dmwe  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.dmwe      = 1'b0;
        bus.dmbe      = '0;
        bus.maddr     = '0;
        bus.wdata     = '0;
        bus.out_ready = 1'b0;
        bus.clr_drop  = 1'b0;
        #3;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_level", 32'(bus.level), 32'h0);
        check("rst_halt", 32'(bus.halt), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // T2 latency and order
        st(32'h00100000, 32'h11, 4'hF);
        check("t2_valid", 32'(bus.out_valid), 32'h1);
        check("t2_first", bus.out_data, 32'h11);
        st(32'h00100001, 32'h22, 4'h3);
        check("t2_level", 32'(bus.level), 32'h2);
        bus.out_ready = 1'b1;
        check("t2_head0", bus.out_data, 32'h11);
        cyc();
        check("t2_head1", bus.out_data, 32'h22);
        check("t2_be1", 32'(bus.out_be), 32'h3);
        cyc();
        check("t2_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // T3 overflow, CLR_DROP priority, ordered drain
        for (int i = 0; i < 18; i++) st(32'h00100000 + 32'(i), 32'(i + 1), 4'hF);
        check("t3_level", 32'(bus.level), 32'd16);
        check("t3_drop", 32'(bus.drop_cnt), 32'd2);
        bus.clr_drop = 1'b1;
        st(32'h00100100, 32'h99, 4'hF);
        bus.clr_drop = 1'b0;
        check("t3_clr", 32'(bus.drop_cnt), 32'd0);
        st(32'h00100101, 32'h98, 4'hF);
        check("t3_drop1", 32'(bus.drop_cnt), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", bus.out_data, 32'(i + 1));
            cyc();
        end
        check("t3_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // T1 asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) st(32'h00100020 + 32'(i), 32'(i), 4'hF);
        check("t1_level5", 32'(bus.level), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t1_valid", 32'(bus.out_valid), 32'h0);
        check("t1_level", 32'(bus.level), 32'h0);
        check("t1_drop", 32'(bus.drop_cnt), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // T4 push and pop together while full
        for (int i = 0; i < 16; i++) st(32'h00100000 + 32'(i), 32'h100 + 32'(i), 4'hF);
        check("t4_full", 32'(bus.level), 32'd16);
        bus.out_ready = 1'b1;
        st(32'h00100010, 32'hAB, 4'hF);
        check("t4_level", 32'(bus.level), 32'd16);
        check("t4_drop", 32'(bus.drop_cnt), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check("t4_drain", bus.out_data, 32'h100 + 32'(i));
            cyc();
        end
        check("t4_last", bus.out_data, 32'hAB);
        cyc();
        check("t4_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // T6 window filter and halt
        st(32'h00100005, 32'h77, 4'h1);
        st(32'h00200000, 32'h1234, 4'hF);
        check("t6_filter", 32'(bus.level), 32'd1);
        st(HALT_A, 32'h0, 4'h1);
        check("t6_halt", 32'(bus.halt), 32'h1);
        check("t6_code", bus.halt_code, 32'h0);
        check("t6_level", 32'(bus.level), 32'd1);
        st(HALT_A, 32'h5, 4'hF);
        check("t6_code2", bus.halt_code, 32'h0);
        check("t6_halt2", 32'(bus.halt), 32'h1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // T5 randomized traffic with wrap, overflow bursts and random drain
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r             = $urandom_range(0, 15);
            bus.dmwe      = ($urandom_range(0, 3) != 0);
            bus.maddr     = (r == 0) ? (32'h00200000 | ($urandom() & 32'hFFFFF)) :
                            (r == 1) ? HALT_A :
                                       (32'h00100000 | ($urandom() & 32'hFFFFE));
            bus.wdata     = $urandom();
            bus.dmbe      = 4'($urandom());
            bus.out_ready = ((i / 60) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                                : ($urandom_range(0, 3) != 0);
            bus.clr_drop  = ($urandom_range(0, 40) == 0);
            cyc();
        end
        bus.dmwe      = 1'b0;
        bus.clr_drop  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check("t5_drained", 32'(bus.level), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
